sys_bridge_n: RTL and testbench
===============================

Name: sys_bridge_n

Overview:
- Parametrised successor to the CPU–device system bridge.
- Decodes the processor's memory-mapped I/O window into NDEV 16-byte device slots.
- Runs a request/acknowledge handshake with wait-state and timeout support, and extracts byte/halfword read data with sign or zero extension.
- Synchronises device interrupts onto HWInt[7:2] for CP0.

Parameters:
- NDEV, 3, number of device slots (1..6); slot i owns one interrupt line.
- BASE, 32'h0000_7F00, byte address of slot 0; must be 16-byte aligned; slot i base = BASE + 16*i.
- TIMEOUT, 15, maximum ACCESS cycles without DEV_Ready before bus error (1..255).
- MASK_ADDR, 32'h0000_7FF0, word address of the interrupt mask register (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- PrReq  in  1  CPU request; held high until PrAck.
- PrAddr  in  30  word address [31:2].
- PrWD  in  32  CPU write data.
- PrWe  in  1  write request.
- BE  in  4  byte enables; 0000 or 1111 = word.
- PrUnsigned  in  1  1 = zero-extend sub-word reads.
- PrRD  out  32  read data, registered.
- PrAck  out  1  one-cycle completion pulse.
- PrErr  out  1  valid with PrAck; unmapped address or timeout.
- HWInt  out  6  interrupt lines [7:2] to CP0.
- DEV_Addr  out  2  register offset [3:2] within the slot.
- DEV_WD  out  32  latched write data.
- DEV_Sel  out  NDEV  one-hot slot select.
- DEV_we  out  NDEV  per-slot write enable.
- DEV_RD  in  32*NDEV  slot i read data at bits [32i+31:32i].
- DEV_Ready  in  NDEV  slot i completes this cycle.
- DEV_IRQ  in  NDEV  level interrupt from slot i.

Behaviour:
- Reset (synchronous, active-high): state IDLE; PrRD=0, PrAck=0, PrErr=0, DEV_Sel=0, DEV_we=0, DEV_Addr=0, DEV_WD=0, HWInt=0, timeout counter=0. Reset mid-transaction aborts it with no PrAck.
- Decode: slot i hit when PrAddr[31:4] == BASE[31:4]+i, for i < NDEV. At most one hit.
- State machine IDLE / ACCESS / DONE:
  - IDLE, PrReq=1: latch PrAddr, PrWD, PrWe, BE, PrUnsigned and the decode result.
    - Hit: go to ACCESS and clear the counter.
    - Miss: go to DONE with PrErr=1 and PrRD=0.
  - ACCESS: DEV_Sel[i]=1 and DEV_we[i]=latched PrWe, held every cycle.
    - DEV_Ready[i]=1: capture read data and go to DONE with PrErr=0. Ready takes priority over timeout in the same cycle.
    - Otherwise counter+1. When counter==TIMEOUT, go to DONE with PrErr=1 and PrRD unchanged.
    - Devices commit a write on the cycle they assert Ready.
  - DONE: PrAck=1 for exactly one cycle, DEV_Sel=0, DEV_we=0, then IDLE. The CPU drops PrReq the cycle after PrAck. A request is accepted only in IDLE.
- Minimum latency: request cycle N, zero-wait Ready in N+1, PrAck in N+2.
- Read extraction (from the selected slot's word W):
  - BE 0000/1111: W.
  - BE 0001/0010/0100/1000: byte 0/1/2/3.
  - BE 0011/1100: halfword 0/1.
  - Sub-word results are sign-extended, or zero-extended when PrUnsigned=1.
  - Any other BE pattern returns W.
  - Writes leave PrRD unchanged.
- Interrupts: DEV_IRQ is registered once (1-cycle latency). HWInt = {zeros, irq_q[NDEV-1:0]}, with slot 0 on HWInt[2] and unused bits 0.

Optional Feature:
- Macro BRIDGE_IRQ_MASK_EN.
- Defined:
  - Internal register irq_mask[NDEV-1:0], reset to all ones, at word address MASK_ADDR.
  - Access completes as a zero-wait slot: write stores PrWD[NDEV-1:0]; read returns the mask zero-extended, with BE extraction applied.
  - HWInt = irq_q & irq_mask.
- Undefined: MASK_ADDR is unmapped (PrErr) and HWInt = irq_q.

Decomposition:
- Package bridge_pkg: state enum (IDLE, ACCESS, DONE), BE pattern constants, slot-size constant 16.
- One natural sub-module: bridge_rd_extract, a combinational function of W, BE and PrUnsigned.

Test Plan:
- Read slot 1 at 0x7F14, BE=0000, Ready immediate, DEV_RD1=0xDEADBEEF -> PrAck two cycles after request, PrRD=0xDEADBEEF, PrErr=0, DEV_Addr=01.
- Read slot 0 with BE=0100, W=0x0080_0000: PrUnsigned=0 -> PrRD=0xFFFFFF80; PrUnsigned=1 -> PrRD=0x00000080.
- Write 0x12345678 to slot 2 with Ready delayed 3 cycles -> DEV_we[2] and DEV_Sel[2] held for 4 ACCESS cycles, DEV_WD=0x12345678, PrAck after Ready, PrErr=0.
- Ready never asserted, TIMEOUT=15 -> PrAck with PrErr=1 on the 17th cycle after request; Ready and timeout in the same cycle -> PrErr=0.
- Access 0x7F40 with NDEV=3 -> PrAck with PrErr=1, PrRD=0; reset asserted mid-ACCESS -> no PrAck, all outputs 0 next cycle.
- DEV_IRQ[0] raised -> HWInt[2]=1 one cycle later. With BRIDGE_IRQ_MASK_EN, writing 0 to MASK_ADDR -> HWInt=0, and a read of MASK_ADDR returns 0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-device system bridge: FSM states,
// byte-enable patterns and the device slot size.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;

  localparam int SLOT_BYTES = 16;

endpackage

// File: rtl/bridge_rd_extract.sv
// Byte/halfword extraction of a device read word with sign or zero extension.
module bridge_rd_extract
  import bridge_pkg::*;
(
  input  logic [31:0] w,
  input  logic [3:0]  be,
  input  logic        is_unsigned,
  output logic [31:0] rd
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sub_byte;
  logic        sub_half;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    b        = 8'h00;
    h        = 16'h0000;
    sub_byte = 1'b0;
    sub_half = 1'b0;
    case (be)
      BE_B0: begin b = w[7:0];   sub_byte = 1'b1; end
      BE_B1: begin b = w[15:8];  sub_byte = 1'b1; end
      BE_B2: begin b = w[23:16]; sub_byte = 1'b1; end
      BE_B3: begin b = w[31:24]; sub_byte = 1'b1; end
      BE_H0: begin h = w[15:0];  sub_half = 1'b1; end
      BE_H1: begin h = w[31:16]; sub_half = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    rd = w;
    if (sub_byte)
      rd = {{24{~is_unsigned & b[7]}}, b};
    else if (sub_half)
      rd = {{16{~is_unsigned & h[15]}}, h};
  end

endmodule

// File: rtl/sys_bridge_n.sv
// CPU-device system bridge: NDEV 16-byte slots, wait-state/timeout handshake,
// sub-word read extraction, interrupt sync. Optional mask: BRIDGE_IRQ_MASK_EN.
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int          NDEV      = 3,
  parameter logic [31:0] BASE      = 32'h0000_7F00,
  parameter int          TIMEOUT   = 15,
  parameter logic [31:0] MASK_ADDR = 32'h0000_7FF0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PrReq,
  input  logic [29:0]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic                 PrWe,
  input  logic [3:0]           BE,
  input  logic                 PrUnsigned,
  output logic [31:0]          PrRD,
  output logic                 PrAck,
  output logic                 PrErr,
  output logic [5:0]           HWInt,
  output logic [1:0]           DEV_Addr,
  output logic [31:0]          DEV_WD,
  output logic [NDEV-1:0]      DEV_Sel,
  output logic [NDEV-1:0]      DEV_we,
  input  logic [32*NDEV-1:0]   DEV_RD,
  input  logic [NDEV-1:0]      DEV_Ready,
  input  logic [NDEV-1:0]      DEV_IRQ
);

`ifdef BRIDGE_IRQ_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t          state_q, state_d;
  logic [NDEV-1:0] hit, sel_q, irq_q, irq_mask;
  logic            mask_hit, mask_q, any_hit;
  logic            we_q, uns_q, err_q;
  logic            complete, timed_out, ready_sel;
  logic [1:0]      addr_q;
  logic [3:0]      be_q;
  logic [31:0]     wd_q, rd_q, word, rd_ext;
  logic [7:0]      cnt_q;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NDEV; i++)
      hit[i] = (PrAddr[29:2] == 28'((BASE + 32'(SLOT_BYTES * i)) >> 4));
  end

  assign mask_hit = MASK_EN && (PrAddr == MASK_ADDR[31:2]);
  assign any_hit  = (|hit) | mask_hit;

  // The mask register behaves as a slot that is always ready.
  always_comb begin
    word = '0;
    for (int i = 0; i < NDEV; i++)
      if (sel_q[i]) word = DEV_RD[32*i +: 32];
    if (mask_q) word = 32'(irq_mask);
  end

  assign ready_sel = (|(DEV_Ready & sel_q)) | mask_q;

  bridge_rd_extract u_extract (
    .w           (word),
    .be          (be_q),
    .is_unsigned (uns_q),
    .rd          (rd_ext)
  );

  always_comb begin
    state_d   = state_q;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE:   if (PrReq) state_d = any_hit ? ACCESS : DONE;
      ACCESS: begin
        if (ready_sel) begin
          state_d  = DONE;
          complete = 1'b1;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d   = DONE;
          timed_out = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mask_q  <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= DEV_IRQ;
      case (state_q)
        IDLE: if (PrReq) begin
          addr_q <= PrAddr[1:0];
          wd_q   <= PrWD;
          we_q   <= PrWe;
          be_q   <= BE;
          uns_q  <= PrUnsigned;
          sel_q  <= hit;
          mask_q <= mask_hit;
          cnt_q  <= '0;
          err_q  <= ~any_hit;
          if (!any_hit) rd_q <= '0;
        end
        ACCESS: begin
          if (complete) begin
            err_q <= 1'b0;
            if (!we_q) rd_q <= rd_ext;
          end else if (timed_out) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRIDGE_IRQ_MASK_EN
  always_ff @(posedge clk) begin
    if (reset)
      irq_mask <= '1;
    else if (state_q == ACCESS && mask_q && we_q)
      irq_mask <= wd_q[NDEV-1:0];
  end
`else
  assign irq_mask = '1;
`endif

  assign PrRD     = rd_q;
  assign PrAck    = (state_q == DONE);
  assign PrErr    = PrAck & err_q;
  assign DEV_Addr = addr_q;
  assign DEV_WD   = wd_q;
  assign DEV_Sel  = sel_q & {NDEV{state_q == ACCESS}};
  assign DEV_we   = sel_q & {NDEV{(state_q == ACCESS) & we_q}};
  assign HWInt    = 6'(irq_q & irq_mask);

endmodule

// File: tb/tb_sys_bridge_n.sv
// Scoreboard bench for sys_bridge_n (NDEV=3): directed transactions push
// expected completions; a negedge monitor checks them on every PrAck.
module tb_sys_bridge_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PrReq = 1'b0;
  logic [29:0] PrAddr = '0;
  logic [31:0] PrWD = '0;
  logic        PrWe = 1'b0;
  logic [3:0]  BE = '0;
  logic        PrUnsigned = 1'b0;
  logic [31:0] PrRD;
  logic        PrAck, PrErr;
  logic [5:0]  HWInt;
  logic [1:0]  DEV_Addr;
  logic [31:0] DEV_WD;
  logic [2:0]  DEV_Sel, DEV_we;
  logic [95:0] dev_rd = '0;
  logic [2:0]  DEV_Ready = '0;
  logic [2:0]  DEV_IRQ = '0;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [1:0]  addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   ready_delay = -1;
  int   acc_cycle = 0;
  int   we_cycles = 0;
  int   saw_ack = 0;

  sys_bridge_n dut (
    .clk        (clk),
    .reset      (reset),
    .PrReq      (PrReq),
    .PrAddr     (PrAddr),
    .PrWD       (PrWD),
    .PrWe       (PrWe),
    .BE         (BE),
    .PrUnsigned (PrUnsigned),
    .PrRD       (PrRD),
    .PrAck      (PrAck),
    .PrErr      (PrErr),
    .HWInt      (HWInt),
    .DEV_Addr   (DEV_Addr),
    .DEV_WD     (DEV_WD),
    .DEV_Sel    (DEV_Sel),
    .DEV_we     (DEV_we),
    .DEV_RD     (dev_rd),
    .DEV_Ready  (DEV_Ready),
    .DEV_IRQ    (DEV_IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Device model: asserts Ready on the ready_delay-th ACCESS cycle.
  always @(posedge clk) begin
    #2;
    if (|DEV_Sel) begin
      DEV_Ready = (acc_cycle == ready_delay) ? DEV_Sel : 3'b000;
      if (|(DEV_Sel & DEV_we)) we_cycles++;
      acc_cycle++;
    end else begin
      DEV_Ready = 3'b000;
      acc_cycle = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && PrAck) begin
      saw_ack++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_rd", PrRD, mon_e.rd);
        check("ack_err", 32'(PrErr), 32'(mon_e.err));
        check("ack_dev_addr", 32'(DEV_Addr), 32'(mon_e.addr));
      end
    end
  end

  task automatic do_req(input logic [31:0] byte_addr, input logic [31:0] wd, input logic we,
                        input logic [3:0] be, input logic uns, input int rdy,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    sb.push_back('{rd: exp_rd, err: exp_err, addr: byte_addr[3:2]});
    ready_delay = rdy;
    @(posedge clk);
    #1;
    PrReq = 1'b1; PrAddr = byte_addr[31:2]; PrWD = wd; PrWe = we; BE = be; PrUnsigned = uns;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (PrAck) begin
        lat = i;
        break;
      end
    end
    check("ack_latency", 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    PrReq = 1'b0; PrWe = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(PrAck), 32'd0);
    check("reset_rd", PrRD, 32'd0);
    check("reset_sel", 32'(DEV_Sel), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Zero-wait word read from slot 1.
    dev_rd[63:32] = 32'hDEAD_BEEF;
    do_req(32'h7F14, 32'h0, 1'b0, 4'b0000, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 2);

    // Byte 2 of slot 0, signed then unsigned.
    dev_rd[31:0] = 32'h0080_0000;
    do_req(32'h7F08, 32'h0, 1'b0, 4'b0100, 1'b0, 0, 32'hFFFF_FF80, 1'b0, 2);
    do_req(32'h7F08, 32'h0, 1'b0, 4'b0100, 1'b1, 0, 32'h0000_0080, 1'b0, 2);

    // Write slot 2 with Ready on the fourth ACCESS cycle; PrRD must not change.
    we_cycles = 0;
    do_req(32'h7F20, 32'h1234_5678, 1'b1, 4'b1111, 1'b0, 3, 32'h0000_0080, 1'b0, 5);
    check("write_we_cycles", 32'(we_cycles), 32'd4);
    check("write_dev_wd", DEV_WD, 32'h1234_5678);

    // Timeout, then Ready colliding with the timeout cycle.
    do_req(32'h7F04, 32'h0, 1'b0, 4'b0000, 1'b0, -1, 32'h0000_0080, 1'b1, 17);
    do_req(32'h7F00, 32'h0, 1'b0, 4'b1111, 1'b0, 15, 32'h0080_0000, 1'b0, 17);

    // Unmapped slot index 4.
    do_req(32'h7F40, 32'h0, 1'b0, 4'b0000, 1'b0, 0, 32'h0000_0000, 1'b1, 1);

    // Sub-word extraction on slot 1.
    dev_rd[63:32] = 32'h8001_1234;
    do_req(32'h7F18, 32'h0, 1'b0, 4'b1100, 1'b0, 0, 32'hFFFF_8001, 1'b0, 2);
    do_req(32'h7F1C, 32'h0, 1'b0, 4'b0011, 1'b1, 0, 32'h0000_1234, 1'b0, 2);
    do_req(32'h7F14, 32'h0, 1'b0, 4'b1000, 1'b0, 0, 32'hFFFF_FF80, 1'b0, 2);
    do_req(32'h7F10, 32'h0, 1'b0, 4'b0101, 1'b1, 0, 32'h8001_1234, 1'b0, 2);

    // Reset during ACCESS aborts the transaction and clears outputs.
    DEV_IRQ = 3'b010;
    ready_delay = -1;
    saw_ack = 0;
    @(posedge clk);
    #1;
    PrReq = 1'b1; PrAddr = 30'(32'h7F08 >> 2); PrWD = 32'hA5A5_A5A5; PrWe = 1'b1; BE = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_sel", 32'(DEV_Sel), 32'b001);
    check("pre_reset_hwint", 32'(HWInt), 32'b000010);
    @(posedge clk);
    #1;
    reset = 1'b1; PrReq = 1'b0; PrWe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rd", PrRD, 32'd0);
    check("rst_sel_we", {26'd0, DEV_Sel, DEV_we}, 32'd0);
    check("rst_addr_wd", DEV_WD | 32'(DEV_Addr), 32'd0);
    check("rst_hwint", 32'(HWInt), 32'd0);
    check("rst_ack_err", 32'({PrAck, PrErr}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_ack_after_reset", 32'(saw_ack), 32'd0);

    // Interrupt synchronisation.
    DEV_IRQ = 3'b000;
    repeat (2) @(posedge clk);
    #1 DEV_IRQ = 3'b001;
    @(negedge clk);
    check("irq_not_yet", 32'(HWInt), 32'd0);
    @(negedge clk);
    check("irq_slot0", 32'(HWInt), 32'b000001);
    @(posedge clk);
    #1 DEV_IRQ = 3'b101;
    @(negedge clk);
    @(negedge clk);
    check("irq_slot0_2", 32'(HWInt), 32'b000101);

    do_req(32'h7F14, 32'h0, 1'b0, 4'b0000, 1'b0, 0, 32'h8001_1234, 1'b0, 2);
`ifdef BRIDGE_IRQ_MASK_EN
    do_req(32'h7FF0, 32'h0, 1'b1, 4'b0000, 1'b0, -1, 32'h8001_1234, 1'b0, 2);
    check("masked_hwint", 32'(HWInt), 32'd0);
    do_req(32'h7FF0, 32'h0, 1'b0, 4'b0000, 1'b0, -1, 32'h0000_0000, 1'b0, 2);
    do_req(32'h7FF0, 32'h0000_0005, 1'b1, 4'b1111, 1'b0, -1, 32'h0000_0000, 1'b0, 2);
    check("unmasked_hwint", 32'(HWInt), 32'b000101);
`else
    do_req(32'h7FF0, 32'h0, 1'b1, 4'b0000, 1'b0, -1, 32'h0000_0000, 1'b1, 1);
    check("unmasked_hwint", 32'(HWInt), 32'b000101);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
